// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table: counter encodings,
// the saturating 2-bit counter step, and PC field extraction.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // Next value of a 2-bit saturating direction counter.
  function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : cnt + 2'd1;
    else       return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

  // pc[lo +: w], zero-extended; used for both the index and the tag field.
  function automatic logic [63:0] pc_field(input logic [63:0] pc, input int lo, input int w);
    return (pc >> lo) & ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module bp_stat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled events, holding once saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (en && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table + target buffer with bimodal or gshare indexing.
// Lookup is combinational from current state; updates land on the clock
// edge at the index carried down the pipe with the branch.
module bht_predictor import bp_pkg::*; #(
  parameter  int         XLEN     = 32,
  parameter  int         ENTRIES  = 64,
  parameter  int         GHR_W    = 0,
  parameter  int         TAG_W    = 8,
  parameter  logic [1:0] CNT_INIT = WNT,
  parameter  int         STAT_W   = 16,
  localparam int         INDEX_W  = $clog2(ENTRIES),
  localparam int         GW       = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc_f,
  input  logic               is_branch_f,
  output logic               predict_taken_f,
  output logic               predict_hit_f,
  output logic [XLEN-1:0]    predict_target_f,
  output logic [INDEX_W-1:0] pred_index_f,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic [XLEN-1:0]    upd_pc,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  input  logic [XLEN-1:0]    upd_target,
  output logic [GW-1:0]      ghr_out,
  output logic [STAT_W-1:0]  stat_branches,
  output logic [STAT_W-1:0]  stat_mispredicts
);

  // Flop arrays rather than RAM so the F-stage read needs no clock.
  logic               valid_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [XLEN-1:0]    tgt_q   [ENTRIES];
  logic [1:0]         cnt_q   [ENTRIES];
  logic [GW-1:0]      ghr_q;

  logic [INDEX_W-1:0] idx_pc_f, idx_f;
  logic [TAG_W-1:0]   tag_f, tag_u;
  logic               upd_hit;

  assign idx_pc_f = INDEX_W'(pc_field(64'(pc_f), 2, INDEX_W));
  assign tag_f    = TAG_W'(pc_field(64'(pc_f), INDEX_W + 2, TAG_W));
  assign tag_u    = TAG_W'(pc_field(64'(upd_pc), INDEX_W + 2, TAG_W));

  generate
    if (GHR_W > 0) begin : g_gshare
      assign idx_f = idx_pc_f ^ INDEX_W'(ghr_q);
      // Committed history: shifts in resolved outcomes only.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)            ghr_q <= '0;
        else if (upd_valid) ghr_q <= GW'({ghr_q, upd_taken});
      end
    end else begin : g_bimodal
      assign idx_f = idx_pc_f;
      assign ghr_q = '0;
    end
  endgenerate

  assign pred_index_f     = idx_f;
  assign predict_hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign predict_taken_f  = is_branch_f && predict_hit_f && cnt_q[idx_f][1];
  assign predict_target_f = tgt_q[idx_f];
  assign ghr_out          = ghr_q;

  // The update never recomputes the index: it trusts the one used at fetch.
  assign upd_hit = valid_q[upd_index] && (tag_q[upd_index] == tag_u);

  // Table update: train on hit, allocate on a taken miss, ignore not-taken misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_INIT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        cnt_q[upd_index] <= sat2_next(cnt_q[upd_index], upd_taken);
        if (upd_taken) tgt_q[upd_index] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_index] <= 1'b1;
        tag_q[upd_index]   <= tag_u;
        tgt_q[upd_index]   <= upd_target;
        cnt_q[upd_index]   <= WT;
      end
    end
  end

  bp_stat_counter #(.W(STAT_W)) u_stat_br (
    .clk   (clk),
    .rst   (rst),
    .en    (upd_valid),
    .count (stat_branches)
  );

  bp_stat_counter #(.W(STAT_W)) u_stat_mis (
    .clk   (clk),
    .rst   (rst),
    .en    (upd_valid && upd_mispredict),
    .count (stat_mispredicts)
  );

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Parametrised successor to the single-state 2-bit branch predictor in the five-stage MIPS pipeline.
- Holds ENTRIES 2-bit saturating counters, each with a tag, a branch target and a valid bit (BHT plus BTB).
- Index mode is selectable: bimodal (GHR_W=0) or gshare (GHR XOR PC).
- Lookup is combinational in the F stage. Update is registered, driven from the D stage when a branch resolves. Saturating statistics counters are included.

Parameters:
XLEN, 32, width of PC and target
ENTRIES, 64, table depth; power of two, >=2
INDEX_W, log2(ENTRIES), derived localparam, not overridable
GHR_W, 0, global-history bits; 0 = bimodal, 1..INDEX_W = gshare
TAG_W, 8, tag bits taken from PC above the index field
CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken)
STAT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
pc_f  in  XLEN  fetch-stage PC
is_branch_f  in  1  fetch instruction is a conditional branch (opcode decode done outside)
predict_taken_f  out  1  predict taken: redirect fetch to predict_target_f
predict_hit_f  out  1  valid entry with matching tag
predict_target_f  out  XLEN  stored target for the indexed entry
pred_index_f  out  INDEX_W  index used for this lookup; carried through IF/ID
upd_valid  in  1  a branch resolved in D this cycle
upd_index  in  INDEX_W  pred_index_f carried with that branch
upd_pc  in  XLEN  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_mispredict  in  1  predicted direction or target was wrong
upd_target  in  XLEN  actual taken target (PCBranchD)
ghr_out  out  max(GHR_W,1)  committed global history; reads 0 when GHR_W=0
stat_branches  out  STAT_W  count of resolved branches
stat_mispredicts  out  STAT_W  count of mispredicts

Behaviour:
- Field extraction: idx_pc = pc[INDEX_W+1:2]; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].
- pred_index_f = idx_pc XOR {zeros, ghr[GHR_W-1:0]} (GHR in the low bits). For GHR_W=0, pred_index_f = idx_pc.
- Lookup is purely combinational from current state; zero-cycle latency.
  - predict_hit_f = valid[idx] && tag[idx]==tag(pc_f).
  - predict_taken_f = is_branch_f && predict_hit_f && cnt[idx][1].
  - predict_target_f = target[idx], independent of hit.
- Update takes effect at the clock edge when upd_valid=1, always at upd_index (never recomputed).
  - Hit (valid && tag match): counter saturates: taken increments toward 11 and holds at 11; not-taken decrements toward 00 and holds at 00. If taken, target <= upd_target.
  - Miss, taken: allocate. valid<=1, tag<=tag(upd_pc), target<=upd_target, cnt<=2'b10.
  - Miss, not-taken: table unchanged.
  - GHR (GHR_W>0): ghr <= {ghr[GHR_W-2:0], upd_taken}; for GHR_W=1, ghr <= upd_taken. GHR is non-speculative: it updates only on upd_valid.
  - stat_branches increments on every update; stat_mispredicts increments when upd_mispredict=1. Both saturate at all-ones (no wrap).
- Simultaneous lookup and update to the same index: lookup returns pre-update state; no bypass.
- upd_valid=0: no state changes.
- Reset: all valid<=0, all cnt<=CNT_INIT, ghr<=0, stats<=0. An update on the reset cycle is dropped.
- Output values immediately after reset: predict_taken_f=0, predict_hit_f=0, ghr_out=0. predict_target_f is undefined by content; bench checks it only on hit.
- Reset asserted mid-operation: state clears asynchronously, with no partial update.
- Targets and tags reset to 0 so the RTL holds no X state.

Decomposition:
- Package bp_pkg:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Function sat2_next(cnt, taken).
  - Function for idx/tag field extraction.
- Sub-module bp_stat_counter (STAT_W, saturating increment with enable, async reset); instantiated twice.
- Table is flop arrays, not RAM, because lookup is combinational.

Test Plan:
- Reset, then pc_f=0x40, is_branch_f=1 -> predict_hit_f=0, predict_taken_f=0, stats=0, ghr_out=0.
- Bimodal: one update with upd_pc=0x40, taken, target 0x100 -> next cycle pc_f=0x40 gives hit=1, taken=1 (cnt=10), target=0x100. Two not-taken updates -> cnt=00, taken=0, hit=1.
- Saturation: five taken updates on one entry -> cnt holds 11; one not-taken -> 10, still predicts taken.
- Alias and miss: ENTRIES=64, pc 0x40 allocated; lookup at 0x40+256 (same index, different tag) -> hit=0, taken=0. A not-taken update at the alias leaves entry 0x40 intact.
- Gshare GHR_W=4: updates taken, not-taken, taken, taken -> ghr_out=4'b1011. pred_index_f for pc 0x40 = 16 XOR 11 = 27.
- Stats: STAT_W=4, 20 updates with 3 mispredicts -> stat_branches=15 (saturated), stat_mispredicts=3. Assert rst mid-stream with upd_valid=1 -> all cleared, update dropped.
